// File: rtl/r5p_mem_arb.sv
// Two-to-one arbiter that shares one single-port memory between the r5p IF and LS buses.
// LS has fixed priority. A saturating wait counter forces an IF grant so IF cannot starve.
module r5p_mem_arb #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned BW       = DW/8,
   parameter int unsigned MAX_WAIT = 4
)(
   input  logic          clk,
   input  logic          rst,
   // instruction fetch manager
   input  logic          if_vld,
   input  logic          if_wen,
   input  logic [AW-1:0] if_adr,
   input  logic [BW-1:0] if_ben,
   input  logic [DW-1:0] if_wdt,
   output logic [DW-1:0] if_rdt,
   output logic          if_rdy,
   // load/store manager
   input  logic          ls_vld,
   input  logic          ls_wen,
   input  logic [AW-1:0] ls_adr,
   input  logic [BW-1:0] ls_ben,
   input  logic [DW-1:0] ls_wdt,
   output logic [DW-1:0] ls_rdt,
   output logic          ls_rdy,
   // memory subordinate
   output logic          m_vld,
   output logic          m_wen,
   output logic [AW-1:0] m_adr,
   output logic [BW-1:0] m_ben,
   output logic [DW-1:0] m_wdt,
   input  logic [DW-1:0] m_rdt,
   input  logic          m_rdy
);

   localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

   logic          gnt_if;
   logic          gnt_ls;
   logic          if_hs;
   logic          rd_hs;
   logic [7:0]    wait_cnt;
   logic          rsp_vld;
   logic          rsp_sel;
   logic [DW-1:0] if_hold;
   logic [DW-1:0] ls_hold;

   // LS wins a conflict unless IF has already waited the maximum number of cycles
   always_comb begin
      gnt_ls = ls_vld & ~(if_vld & (wait_cnt == WAIT_LIM));
      gnt_if = if_vld & ~gnt_ls;
   end

   always_comb begin
      m_vld = if_vld | ls_vld;
      if (gnt_if) begin
         m_wen = if_wen;
         m_adr = if_adr;
         m_ben = if_ben;
         m_wdt = if_wdt;
      end else begin
         m_wen = ls_wen;
         m_adr = ls_adr;
         m_ben = ls_ben;
         m_wdt = ls_wdt;
      end
      if_rdy = gnt_if & m_rdy;
      ls_rdy = gnt_ls & m_rdy;
      if_hs  = if_vld & if_rdy;
      rd_hs  = m_vld & m_rdy & ~m_wen;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= 8'd0;
      end else if (!if_vld || if_hs) begin
         wait_cnt <= 8'd0;
      end else if (wait_cnt < WAIT_LIM) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Remembers which port issued the read, so the next cycle's memory data goes to that port
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_vld <= 1'b0;
         rsp_sel <= 1'b0;
      end else begin
         rsp_vld <= rd_hs;
         if (rd_hs) begin
            rsp_sel <= gnt_ls;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if_hold <= '0;
         ls_hold <= '0;
      end else if (rsp_vld) begin
         if (rsp_sel) begin
            ls_hold <= m_rdt;
         end else begin
            if_hold <= m_rdt;
         end
      end
   end

   // Fresh data passes straight through in the response cycle, then the hold register keeps it stable
   always_comb begin
      if_rdt = (rsp_vld && !rsp_sel) ? m_rdt : if_hold;
      ls_rdt = (rsp_vld &&  rsp_sel) ? m_rdt : ls_hold;
   end

endmodule

// File: tb/tb_r5p_mem_arb.sv
// Directed-vector bench for r5p_mem_arb, with a behavioural 1-cycle-latency memory behind the arbiter.
// A table covers arbitration, writes and stalls; hand sequences cover reset and alternating traffic.
module tb_r5p_mem_arb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic          clk;
   logic          rst;
   logic          if_vld, if_wen, ls_vld, ls_wen;
   logic [AW-1:0] if_adr, ls_adr, m_adr;
   logic [BW-1:0] if_ben, ls_ben, m_ben;
   logic [DW-1:0] if_wdt, ls_wdt, m_wdt;
   logic [DW-1:0] if_rdt, ls_rdt, m_rdt;
   logic          if_rdy, ls_rdy;
   logic          m_vld, m_wen, m_rdy;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mem [256];

   typedef struct {
      string       nm;
      logic        rst;
      logic        iv;
      logic [31:0] ia;
      logic        lv;
      logic        lw;
      logic [31:0] la;
      logic [3:0]  lb;
      logic [31:0] ld;
      logic        mr;
      logic        e_ir;
      logic        e_lr;
      logic        e_mv;
      logic        e_mw;
      logic [31:0] e_ma;
      logic [31:0] e_if;
      logic [31:0] e_ls;
   } vec_t;

   vec_t vecs [22];

   r5p_mem_arb #(.AW(AW), .DW(DW), .BW(BW), .MAX_WAIT(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .if_vld (if_vld),
      .if_wen (if_wen),
      .if_adr (if_adr),
      .if_ben (if_ben),
      .if_wdt (if_wdt),
      .if_rdt (if_rdt),
      .if_rdy (if_rdy),
      .ls_vld (ls_vld),
      .ls_wen (ls_wen),
      .ls_adr (ls_adr),
      .ls_ben (ls_ben),
      .ls_wdt (ls_wdt),
      .ls_rdt (ls_rdt),
      .ls_rdy (ls_rdy),
      .m_vld  (m_vld),
      .m_wen  (m_wen),
      .m_adr  (m_adr),
      .m_ben  (m_ben),
      .m_wdt  (m_wdt),
      .m_rdt  (m_rdt),
      .m_rdy  (m_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory: byte-enabled writes, read data one cycle after the handshake
   always @(posedge clk) begin
      if (m_vld && m_rdy) begin
         if (m_wen) begin
            for (int b = 0; b < 4; b++) begin
               if (m_ben[b]) mem[m_adr[9:2]][8*b +: 8] <= m_wdt[8*b +: 8];
            end
         end else begin
            m_rdt <= mem[m_adr[9:2]];
         end
      end
   end

   function automatic vec_t mk(input string nm, input logic r,
                               input logic iv, input logic [31:0] ia,
                               input logic lv, input logic lw, input logic [31:0] la,
                               input logic [3:0] lb, input logic [31:0] ld, input logic mr,
                               input logic e_ir, input logic e_lr, input logic e_mv, input logic e_mw,
                               input logic [31:0] e_ma, input logic [31:0] e_if, input logic [31:0] e_ls);
      vec_t v;
      v.nm = nm;   v.rst = r;
      v.iv = iv;   v.ia = ia;
      v.lv = lv;   v.lw = lw;   v.la = la;   v.lb = lb;   v.ld = ld;
      v.mr = mr;
      v.e_ir = e_ir; v.e_lr = e_lr; v.e_mv = e_mv; v.e_mw = e_mw;
      v.e_ma = e_ma; v.e_if = e_if; v.e_ls = e_ls;
      return v;
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst    = v.rst;
      if_vld = v.iv;
      if_wen = 1'b0;
      if_adr = v.ia;
      if_ben = 4'hF;
      if_wdt = 32'h0;
      ls_vld = v.lv;
      ls_wen = v.lw;
      ls_adr = v.la;
      ls_ben = v.lb;
      ls_wdt = v.ld;
      m_rdy  = v.mr;
   endtask

   task automatic checkVector(input vec_t v);
      checkOutput({v.nm, ".if_rdy"}, 32'(if_rdy), 32'(v.e_ir));
      checkOutput({v.nm, ".ls_rdy"}, 32'(ls_rdy), 32'(v.e_lr));
      checkOutput({v.nm, ".m_vld"},  32'(m_vld),  32'(v.e_mv));
      if (v.e_mv) begin
         checkOutput({v.nm, ".m_wen"}, 32'(m_wen), 32'(v.e_mw));
         checkOutput({v.nm, ".m_adr"}, m_adr, v.e_ma);
         if (v.e_mw) begin
            checkOutput({v.nm, ".m_ben"}, 32'(m_ben), 32'(v.lb));
            checkOutput({v.nm, ".m_wdt"}, m_wdt, v.ld);
         end
      end
      checkOutput({v.nm, ".if_rdt"}, if_rdt, v.e_if);
      checkOutput({v.nm, ".ls_rdt"}, ls_rdt, v.e_ls);
   endtask

   task automatic runVec(input vec_t v);
      applyStimulus(v);
      @(negedge clk);
      checkVector(v);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] db, d4, d8, wr;
      logic [31:0] exp_if, exp_ls;
      logic [7:0]  idx;
      db = 32'hDEADBEEF;
      d4 = 32'h10000004;
      d8 = 32'h10000008;
      wr = 32'hAABB5678;

      for (int i = 0; i < 256; i++) mem[i] = 32'h10000000 + 32'(i);
      mem[64]  = 32'hDEADBEEF;
      mem[128] = 32'hAABBCCDD;
      m_rdt    = 32'h0;

      vecs[0]  = mk("reset_idle",  0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0);
      vecs[1]  = mk("if_rd",       0, 1, 32'h100, 0, 0, 32'h0,   4'hF, 32'h0, 1, 1, 0, 1, 0, 32'h100, 32'h0, 32'h0);
      vecs[2]  = mk("if_rsp",      0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   db,    32'h0);
      vecs[3]  = mk("if_hold",     0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   db,    32'h0);
      vecs[4]  = mk("arb_c1",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  db,    32'h0);
      vecs[5]  = mk("arb_c2",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  db,    d8);
      vecs[6]  = mk("arb_c3",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  db,    d8);
      vecs[7]  = mk("arb_c4",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  db,    d8);
      vecs[8]  = mk("arb_c5_if",   0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 1, 0, 1, 0, 32'h10,  db,    d8);
      vecs[9]  = mk("arb_c6",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  d4,    d8);
      vecs[10] = mk("arb_c7",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  d4,    d8);
      vecs[11] = mk("arb_c8",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  d4,    d8);
      vecs[12] = mk("arb_c9",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  d4,    d8);
      vecs[13] = mk("arb_c10_if",  0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 1, 0, 1, 0, 32'h10,  d4,    d8);
      vecs[14] = mk("ls_wr",       0, 0, 32'h0,   1, 1, 32'h200, 4'b0011, 32'h12345678, 1, 0, 1, 1, 1, 32'h200, d4, d8);
      vecs[15] = mk("ls_rd",       0, 0, 32'h0,   1, 0, 32'h200, 4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h200, d4,    d8);
      vecs[16] = mk("ls_rd_rsp",   0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   d4,    wr);
      vecs[17] = mk("stall1",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 0, 0, 0, 1, 0, 32'h20,  d4,    wr);
      vecs[18] = mk("stall2",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 0, 0, 0, 1, 0, 32'h20,  d4,    wr);
      vecs[19] = mk("stall3",      0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 0, 0, 0, 1, 0, 32'h20,  d4,    wr);
      vecs[20] = mk("stall_rel",   0, 1, 32'h10,  1, 0, 32'h20,  4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h20,  d4,    wr);
      vecs[21] = mk("stall_rsp",   0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   d4,    d8);

      applyStimulus(mk("init", 1, 0, 32'h0, 0, 0, 32'h0, 4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 22; i++) runVec(vecs[i]);

      // Reset asserted in the response cycle: data passes through, but the hold register is never written
      runVec(mk("rst_rd",      0, 1, 32'h100, 0, 0, 32'h0,   4'hF, 32'h0, 1, 1, 0, 1, 0, 32'h100, d4,    d8));
      runVec(mk("rst_in_rsp",  1, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   db,    d8));
      runVec(mk("post_rst",    0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0));
      runVec(mk("post_rst_rd", 0, 0, 32'h0,   1, 0, 32'h100, 4'hF, 32'h0, 1, 0, 1, 1, 0, 32'h100, 32'h0, 32'h0));
      runVec(mk("post_rst_rsp",0, 0, 32'h0,   0, 0, 32'h0,   4'hF, 32'h0, 1, 0, 0, 0, 0, 32'h0,   32'h0, db));

      // Alternating IF/LS reads at random addresses; each word must land only on its issuer
      exp_if = 32'h0;
      exp_ls = db;
      for (int k = 0; k < 100; k++) begin
         idx    = 8'($urandom_range(0, 255));
         rst    = 1'b0;
         m_rdy  = 1'b1;
         if_wen = 1'b0;
         ls_wen = 1'b0;
         if_vld = (k % 2 == 0);
         ls_vld = (k % 2 == 1);
         if_adr = {22'd0, idx, 2'b00};
         ls_adr = {22'd0, idx, 2'b00};
         @(negedge clk);
         checkOutput("alt.if_rdt", if_rdt, exp_if);
         checkOutput("alt.ls_rdt", ls_rdt, exp_ls);
         if (k % 2 == 0) begin
            checkOutput("alt.if_rdy", 32'(if_rdy), 32'h1);
            exp_if = mem[idx];
         end else begin
            checkOutput("alt.ls_rdy", 32'(ls_rdy), 32'h1);
            exp_ls = mem[idx];
         end
         @(posedge clk);
         #1;
      end
      if_vld = 1'b0;
      ls_vld = 1'b0;
      @(negedge clk);
      checkOutput("alt_end.if_rdt", if_rdt, exp_if);
      checkOutput("alt_end.ls_rdt", ls_rdt, exp_ls);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
